pc_sequencer: RTL

- Multi-cycle control FSM for the RV32 core. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the PC update selector, IR/register-file write enables and the instruction/data memory request handshakes.
- Handles memory stall timeouts, illegal-instruction traps, external halt and a retired-instruction counter.
- Sits between the decoder (instruction class in) and the PC/ALU/memory datapath.

---
 rtl/pc_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle fetch/decode/execute/mem/writeback sequencer for the RV32 core
// Trap and halt are terminal/parking states; all outputs decode from state and the decoded class.
module pc_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [2:0]           instrClass,
  input  logic                 imemReady,
  input  logic                 dmemReady,
  input  logic                 haltReq,
  output logic                 imemReq,
  output logic                 dmemReq,
  output logic                 dmemWe,
  output logic                 irWrite,
  output logic                 regWrite,
  output logic [1:0]           pcSelector,
  output logic                 halted,
  output logic                 trap,
  output logic [1:0]           trapCause,
  output logic [INSTRET_W-1:0] instret
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] CLS_ALU    = 3'd0;
  localparam logic [2:0] CLS_LOAD   = 3'd1;
  localparam logic [2:0] CLS_STORE  = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_JUMP   = 3'd4;

  localparam logic [1:0] PC_INC  = 2'd0;
  localparam logic [1:0] PC_JMP  = 2'd1;
  localparam logic [1:0] PC_BR   = 2'd2;
  localparam logic [1:0] PC_HOLD = 2'd3;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT,
    S_TRAP
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             cause_q, cause_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    case (state_q)
      S_FETCH: begin
        if (imemReady) begin
          state_d = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IMEM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        case (instrClass)
          CLS_ALU, CLS_BRANCH, CLS_JUMP: state_d = S_WRITEBACK;
          CLS_LOAD, CLS_STORE: begin
            state_d = S_MEM;
            cnt_d   = '0;
          end
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        if (dmemReady) begin
          state_d = S_WRITEBACK;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITEBACK: begin
        instret_d = instret_q + 1'b1;
        cnt_d     = '0;
        state_d   = haltReq ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (!haltReq) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      cause_q   <= 2'd0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Fetch outputs are gated by resetN so every request is low while reset is held.
  always_comb begin
    imemReq    = resetN && (state_q == S_FETCH);
    irWrite    = resetN && (state_q == S_FETCH) && imemReady;
    dmemReq    = (state_q == S_MEM);
    dmemWe     = (state_q == S_MEM) && (instrClass == CLS_STORE);
    regWrite   = (state_q == S_WRITEBACK) &&
                 ((instrClass == CLS_ALU) || (instrClass == CLS_LOAD) || (instrClass == CLS_JUMP));
    pcSelector = PC_HOLD;
    if (state_q == S_WRITEBACK) begin
      if (instrClass == CLS_BRANCH)    pcSelector = PC_BR;
      else if (instrClass == CLS_JUMP) pcSelector = PC_JMP;
      else                             pcSelector = PC_INC;
    end
    halted     = (state_q == S_HALT);
    trap       = (state_q == S_TRAP);
    trapCause  = cause_q;
    instret    = instret_q;
  end

endmodule
